pcs_40g_tx_am_sched: RTL
========================

# pcs_40g_tx_am_sched

Transmit-side block scheduler for the 40G PCS. Owns the per-cycle slot decision for all four lanes. Each cycle is one of three slot types:
- a data block accepted from the MAC,
- an alignment marker (AM) block inserted on every lane,
- a gearbox stall cycle with no block.

It drives MAC backpressure and the gearbox sequence counter. It delays its decisions to match the encoder/scrambler latency, muxes AM blocks into the scrambled stream, and computes the per-lane BIP carried in each AM.

## Interface
- LANE_N, 4, number of PCS lanes
- BLOCK_W, 64, block payload width
- HEAD_W, 2, sync header width
- SEQ_MAX, 32, gearbox sequence value at which the gearbox is full (stall slot)
- SEQ_W, $clog2(SEQ_MAX+1), gearbox sequence width
- AM_PERIOD, 16384, block slots per lane between AM starts (AM included); reduced in simulation
- PIPE_D, 2, cycles from ready_o to the matching scrambled block at scr_*_i; must be ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ready_o  out  1  MAC may present a block this cycle
- scr_v_i  in  1  scrambled blocks valid (upstream echo of a delayed ready_o)
- scr_data_i  in  LANE_N*BLOCK_W  scrambled payload, lane l at [l*64 +: 64]
- scr_head_i  in  LANE_N*HEAD_W  sync headers, lane l at [l*2 +: 2]
- tx_v_o  out  1  tx block valid
- tx_data_o  out  LANE_N*BLOCK_W  block to gearbox, data or AM
- tx_head_o  out  LANE_N*HEAD_W  header to gearbox
- seq_o  out  SEQ_W  gearbox sequence for the tx_* beat
- err_o  out  1  sticky: scr_v_i disagreed with the expected data slot

## Operation
- Cycle sequence counter seq_q:
  - Counts 0..SEQ_MAX, then wraps to 0.
  - When seq_q == SEQ_MAX, the slot is STALL.
- Block counter blk_q:
  - Counts 0..AM_PERIOD-1.
  - Advances only in non-STALL slots and wraps to 0.
- Slot type:
  - STALL has priority.
  - Otherwise blk_q == 0 gives AM.
  - Otherwise the slot is DATA.
  - When STALL and blk_q == 0 coincide, the AM is deferred to the next slot; it is never dropped.
- ready_o = slot is DATA. This is combinational from registered state only and never depends on scr_v_i.
- Slot pipeline: PIPE_D-deep shift register of {slot type, seq_q}. The tail entry governs the output stage.
- Output stage is registered, with one cycle latency after the tail. Behaviour by tail slot type:
  - DATA: forward scr_*_i. If scr_v_i == 0, set err_o and still emit the block.
  - AM: every lane emits head 2'b01 (head[0]=1) and payload bytes {M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3}, with byte 0 = M0 in bits 7:0.
  - STALL: tx_v_o = 0; tx_data_o and tx_head_o hold their previous values.
  - seq_o = tail seq for all slot types.
- Per-lane BIP accumulator bip[7:0]:
  - Every emitted block XORs into it: bip[j] ^= data[j+8k] for k = 0..7.
  - bip[3] ^= head[0]; bip[4] ^= head[1].
  - On an AM beat, BIP3 = the current accumulator value. The accumulator then restarts from that AM block's own contribution, so each AM covers the previous AM through the last data block.
- err_o is also set if scr_v_i == 1 when the tail slot is not DATA. It clears only on reset.

## Timing
- Reset values: ready_o 0, tx_v_o 0, tx_data_o 0, tx_head_o 0, seq_o 0, err_o 0; seq_q, blk_q, and bip all 0; slot pipeline entries are STALL-invalid.
- Sequencing after reset:
  - The first cycle after reset deasserts is an AM slot with ready_o 0.
  - DATA slots begin on the next cycle.
  - The first tx_v_o occurs PIPE_D+1 cycles after reset deasserts, and carries an AM with BIP3 = 0x00.
- Reset asserted mid-period discards the pipeline and the partial BIP. No AM is emitted for the partial period.
- Steady state: ready_o is low for 1 of every SEQ_MAX+1 cycles (gearbox stall), plus one cycle per AM_PERIOD blocks.

## Structure
- Package pcs_40g_pkg:
  - slot type enum {STALL, AM, DATA};
  - AM lane constants:
    - lane0 0x90,0x76,0x47
    - lane1 0xF0,0xC4,0xE6
    - lane2 0xC5,0x65,0x9B
    - lane3 0xA2,0x79,0x3D
  - AM header constant 2'b01.
- Sub-module pcs_bip8, one instance per lane. Inputs: clk, reset, v, am, head, data. Output: bip. It holds the accumulator and the restart-on-AM logic.

## Test plan
- Reset release, AM_PERIOD=8, PIPE_D=2:
  - ready_o is 0 at cycle 0 and 1 at cycles 1-7, then 0 at cycle 8 (AM).
  - The first tx_v_o is at cycle 3 with lane0 payload 0xFF_B8_89_6F_00_47_76_90 and head 2'b01.
- Gearbox stall: the cycle where seq_q == 32 has ready_o 0 and tx_v_o 0 at PIPE_D+1 cycles later; seq_o then reads 32 and wraps to 0.
- Collision, AM_PERIOD=33: a stall coinciding with blk_q == 0 pushes the AM to the following cycle; the block count per period stays 33.
- BIP, AM_PERIOD=2, zero payload, head 2'b10: every AM after the first carries BIP3 0x18 and BIP7 0xE7 on all lanes.
- Handshake mismatch: drive scr_v_i 1 during an AM tail, or 0 during a DATA tail; err_o rises on the following cycle and stays high until reset.
- Mid-period reset: all outputs return to reset values on the next cycle, and the schedule restarts with an AM carrying BIP3 0x00.

Source files
------------

// File: rtl/pcs_40g_tx_am_sched_pkg.sv
// Shared types and constants for the 40G PCS transmit alignment-marker scheduler.
// Latency: none (package only).
// Backpressure: none (package only).
// Contents: slot_e slot type, AM header, per-lane AM marker bytes, AM block builder, BIP-8 contribution.
package pcs_40g_pkg;

    typedef enum logic [1:0] {
        SLOT_STALL = 2'd0,
        SLOT_AM    = 2'd1,
        SLOT_DATA  = 2'd2
    } slot_e;

    localparam logic [1:0] AM_HEAD = 2'b01;

    // Marker bytes packed as {M2, M1, M0}, so M0 lands in bits 7:0.
    // Lanes above 3 reuse the lane 3 marker.
    function automatic logic [23:0] am_marker(input int lane);
        case (lane)
            0:       am_marker = {8'h47, 8'h76, 8'h90};
            1:       am_marker = {8'hE6, 8'hC4, 8'hF0};
            2:       am_marker = {8'h9B, 8'h65, 8'hC5};
            default: am_marker = {8'h3D, 8'h79, 8'hA2};
        endcase
    endfunction

    // Byte order on the wire: M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3.
    function automatic logic [63:0] am_block(input int lane, input logic [7:0] bip);
        logic [23:0] m;
        m = am_marker(lane);
        return {~bip, ~m, bip, m};
    endfunction

    // Bit j of the result is the parity of bit j across all eight payload bytes.
    // The two sync header bits fold into bits 3 and 4.
    function automatic logic [7:0] bip8_contrib(input logic [63:0] data, input logic [1:0] head);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            b = b ^ data[k*8 +: 8];
        end
        b[3] = b[3] ^ head[0];
        b[4] = b[4] ^ head[1];
        return b;
    endfunction

endpackage

// File: rtl/pcs_40g_tx_am_sched_if.sv
// Bus bundle between the scrambler, the AM scheduler and the gearbox.
// Latency: none (wires only).
// Backpressure: ready_o is the only flow control; everything downstream of it is a fixed-latency echo.
// master = scheduler side (drives ready/tx/seq/err); slave = surrounding datapath.
interface pcs_40g_tx_am_sched_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 64,
    parameter int HEAD_W  = 2,
    parameter int SEQ_W   = 6
);
    logic                        ready_o;
    logic                        scr_v_i;
    logic [LANE_N*BLOCK_W-1:0]   scr_data_i;
    logic [LANE_N*HEAD_W-1:0]    scr_head_i;
    logic                        tx_v_o;
    logic [LANE_N*BLOCK_W-1:0]   tx_data_o;
    logic [LANE_N*HEAD_W-1:0]    tx_head_o;
    logic [SEQ_W-1:0]            seq_o;
    logic                        err_o;

    modport master (
        output ready_o, tx_v_o, tx_data_o, tx_head_o, seq_o, err_o,
        input  scr_v_i, scr_data_i, scr_head_i
    );

    modport slave (
        input  ready_o, tx_v_o, tx_data_o, tx_head_o, seq_o, err_o,
        output scr_v_i, scr_data_i, scr_head_i
    );
endinterface

// File: rtl/pcs_40g_tx_am_sched_bip8.sv
// Per-lane BIP-8 accumulator over every emitted block, restarting on each AM.
// Latency: bip_o reflects blocks up to the previous cycle (one register).
// Backpressure: none; v_i simply gates accumulation.
// Ports: clk, reset, v_i (block emitted), am_i (block is an AM), head_i, data_i, bip_o.
module pcs_bip8
    import pcs_40g_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        v_i,
    input  logic        am_i,
    input  logic [1:0]  head_i,
    input  logic [63:0] data_i,
    output logic [7:0]  bip_o
);

    logic [7:0] bip_q;
    logic [7:0] bip_d;

    // On an AM the running value has already been placed in the AM by the
    // caller; the new period starts from the AM block's own contribution.
    always_comb begin
        bip_d = bip_q;
        if (v_i) begin
            bip_d = (am_i ? 8'h00 : bip_q) ^ bip8_contrib(data_i, head_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bip_q <= 8'h00;
        end else begin
            bip_q <= bip_d;
        end
    end

    assign bip_o = bip_q;

endmodule

// File: rtl/pcs_40g_tx_am_sched.sv
// Per-cycle slot scheduler (DATA / AM / gearbox STALL) for the 40G PCS transmit path, with AM insertion and BIP.
// Latency: ready_o -> scrambled echo after PIPE_D cycles -> tx_* one registered cycle later.
// Backpressure: ready_o low on STALL and AM slots; scr_v_i must echo ready_o, disagreement sets sticky err_o.
// Ports: clk, reset, bus (master modport: ready_o, scr_v_i/scr_data_i/scr_head_i, tx_v_o/tx_data_o/tx_head_o, seq_o, err_o).
module pcs_40g_tx_am_sched
    import pcs_40g_pkg::*;
#(
    parameter int LANE_N    = 4,
    parameter int BLOCK_W   = 64,
    parameter int HEAD_W    = 2,
    parameter int SEQ_MAX   = 32,
    parameter int SEQ_W     = $clog2(SEQ_MAX + 1),
    parameter int AM_PERIOD = 16384,
    parameter int PIPE_D    = 2
) (
    input logic                   clk,
    input logic                   reset,
    pcs_40g_tx_am_sched_if.master bus
);

    localparam int BLK_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;

    typedef struct packed {
        slot_e            slot;
        logic [SEQ_W-1:0] seq;
    } pipe_ent_t;

    // ---------------------------------------------------------------
    // Slot decision from registered counters only
    // ---------------------------------------------------------------
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    slot_e            slot;

    always_comb begin
        slot = SLOT_DATA;
        if (seq_q == SEQ_W'(SEQ_MAX)) begin
            slot = SLOT_STALL;
        end else if (blk_q == '0) begin
            slot = SLOT_AM;
        end
    end

    // blk_q holds through a STALL, so an AM due on a stall slot lands on the next one.
    always_comb begin
        seq_d = (seq_q == SEQ_W'(SEQ_MAX)) ? '0 : seq_q + SEQ_W'(1);
        blk_d = blk_q;
        if (slot != SLOT_STALL) begin
            blk_d = (blk_q == BLK_W'(AM_PERIOD - 1)) ? '0 : blk_q + BLK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= '0;
            blk_q <= '0;
        end else begin
            seq_q <= seq_d;
            blk_q <= blk_d;
        end
    end

    assign bus.ready_o = (slot == SLOT_DATA);

    // ---------------------------------------------------------------
    // Slot pipeline matching the encoder/scrambler latency
    // ---------------------------------------------------------------
    pipe_ent_t pipe_q [PIPE_D];
    pipe_ent_t tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_D; i++) begin
                pipe_q[i] <= '{slot: SLOT_STALL, seq: '0};
            end
        end else begin
            pipe_q[0] <= '{slot: slot, seq: seq_q};
            for (int i = 1; i < PIPE_D; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail = pipe_q[PIPE_D-1];

    // ---------------------------------------------------------------
    // Per-lane block mux and BIP
    // ---------------------------------------------------------------
    logic [LANE_N*BLOCK_W-1:0] emit_data;
    logic [LANE_N*HEAD_W-1:0]  emit_head;
    logic                      emit_v;
    logic                      emit_am;

    assign emit_v  = (tail.slot != SLOT_STALL);
    assign emit_am = (tail.slot == SLOT_AM);

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        logic [7:0]         bip;
        logic [BLOCK_W-1:0] lane_data;
        logic [HEAD_W-1:0]  lane_head;

        always_comb begin
            lane_data = bus.scr_data_i[l*BLOCK_W +: BLOCK_W];
            lane_head = bus.scr_head_i[l*HEAD_W +: HEAD_W];
            if (emit_am) begin
                lane_data = am_block(l, bip);
                lane_head = AM_HEAD;
            end
        end

        assign emit_data[l*BLOCK_W +: BLOCK_W] = lane_data;
        assign emit_head[l*HEAD_W +: HEAD_W]   = lane_head;

        pcs_bip8 u_bip8 (
            .clk    (clk),
            .reset  (reset),
            .v_i    (emit_v),
            .am_i   (emit_am),
            .head_i (lane_head),
            .data_i (lane_data),
            .bip_o  (bip)
        );
    end

    // ---------------------------------------------------------------
    // Registered output stage
    // ---------------------------------------------------------------
    logic                      tx_v_q, tx_v_d;
    logic [LANE_N*BLOCK_W-1:0] tx_data_q, tx_data_d;
    logic [LANE_N*HEAD_W-1:0]  tx_head_q, tx_head_d;
    logic [SEQ_W-1:0]          seq_out_q, seq_out_d;
    logic                      err_q, err_d;

    always_comb begin
        tx_v_d    = 1'b0;
        tx_data_d = tx_data_q;
        tx_head_d = tx_head_q;
        seq_out_d = tail.seq;
        err_d     = err_q;
        case (tail.slot)
            SLOT_DATA: begin
                // A missing echo is flagged but the block still goes out to keep the gearbox fed.
                tx_v_d    = 1'b1;
                tx_data_d = emit_data;
                tx_head_d = emit_head;
                if (!bus.scr_v_i) begin
                    err_d = 1'b1;
                end
            end
            SLOT_AM: begin
                tx_v_d    = 1'b1;
                tx_data_d = emit_data;
                tx_head_d = emit_head;
                if (bus.scr_v_i) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                if (bus.scr_v_i) begin
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_v_q    <= 1'b0;
            tx_data_q <= '0;
            tx_head_q <= '0;
            seq_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tx_v_q    <= tx_v_d;
            tx_data_q <= tx_data_d;
            tx_head_q <= tx_head_d;
            seq_out_q <= seq_out_d;
            err_q     <= err_d;
        end
    end

    assign bus.tx_v_o    = tx_v_q;
    assign bus.tx_data_o = tx_data_q;
    assign bus.tx_head_o = tx_head_q;
    assign bus.seq_o     = seq_out_q;
    assign bus.err_o     = err_q;

endmodule
